// File: rtl/hilo_muldiv_sched_if.sv
// EX-side bundle for the HI/LO mul/div scheduler: op issue, HI/LO access requests,
// and the status/result signals returned to the pipeline.
interface hilo_muldiv_sched_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              hilo_rd;
  logic              wr_hi_en;
  logic              wr_lo_en;
  logic [DATA_W-1:0] wr_data;
  logic              cancel_in;
  logic              busy;
  logic              stall_out;
  logic              done_pulse;
  logic              div_zero;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  // Pipeline (EX) side
  modport master (
    output op_valid, op_code, src_a, src_b, hilo_rd,
    output wr_hi_en, wr_lo_en, wr_data, cancel_in,
    input  busy, stall_out, done_pulse, div_zero, hi_out, lo_out
  );

  // Scheduler side
  modport slave (
    input  op_valid, op_code, src_a, src_b, hilo_rd,
    input  wr_hi_en, wr_lo_en, wr_data, cancel_in,
    output busy, stall_out, done_pulse, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_muldiv_sched.sv
// HI/LO register owner with an iterative shift-add multiplier and restoring divider.
// Optional HILO_FAST_MULT_EN: MULT/MULTU complete with a single-cycle combinational multiply.
module hilo_muldiv_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic                clk_sig,
  input logic                rst_sig,
  hilo_muldiv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int              W2       = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  // Multiply: {product_hi, multiplier/product_lo}; divide: {remainder, dividend/quotient}
  logic [W2-1:0]     acc_reg, acc_next;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [DATA_W-1:0] opnd_reg, opnd_next;
  logic              is_div_reg, is_div_next;
  logic              neg_lo_reg, neg_lo_next;
  logic              neg_hi_reg, neg_hi_next;
  logic              dz_reg, dz_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic [DATA_W-1:0] lo_reg, lo_next;

  logic              op_signed, op_is_div;
  logic              sign_a, sign_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   mul_sum;
  logic [W2-1:0]     mul_acc;
  logic [DATA_W:0]   div_shift, div_diff;
  logic [W2-1:0]     div_acc;
  logic [W2-1:0]     mul_res;
  logic [DATA_W-1:0] acc_hi, acc_lo;
  logic [DATA_W-1:0] hi_fin, lo_fin;

  // Operand decode: magnitudes for signed ops, signs kept for final correction
  always_comb begin
    op_signed = bus.op_code[0];
    op_is_div = bus.op_code[1];
    sign_a    = op_signed & bus.src_a[DATA_W-1];
    sign_b    = op_signed & bus.src_b[DATA_W-1];
    abs_a     = sign_a ? -bus.src_a : bus.src_a;
    abs_b     = sign_b ? -bus.src_b : bus.src_b;
  end

  // One shift-add multiply step: conditionally add into the upper half, shift right
  always_comb begin
    mul_sum = {1'b0, acc_reg[W2-1:DATA_W]} + {1'b0, (acc_reg[0] ? opnd_reg : {DATA_W{1'b0}})};
    mul_acc = {mul_sum, acc_reg[DATA_W-1:1]};
  end

  // One restoring divide step; the partial remainder stays below the divisor,
  // so the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    div_shift = {acc_reg[W2-1:DATA_W], acc_reg[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (!div_diff[DATA_W]) begin
      div_acc = {div_diff[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b1};
    end else begin
      div_acc = {div_shift[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b0};
    end
  end

  // Sign correction applied as HI/LO are written on DONE -> IDLE
  always_comb begin
    acc_hi  = acc_reg[W2-1:DATA_W];
    acc_lo  = acc_reg[DATA_W-1:0];
    mul_res = neg_lo_reg ? -acc_reg : acc_reg;
    if (is_div_reg) begin
      hi_fin = neg_hi_reg ? -acc_hi : acc_hi;
      lo_fin = neg_lo_reg ? -acc_lo : acc_lo;
    end else begin
      hi_fin = mul_res[W2-1:DATA_W];
      lo_fin = mul_res[DATA_W-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    is_div_next = is_div_reg;
    neg_lo_next = neg_lo_reg;
    neg_hi_next = neg_hi_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (bus.op_valid) begin
          cnt_next    = '0;
          dz_next     = 1'b0;
          neg_lo_next = sign_a ^ sign_b;
          neg_hi_next = 1'b0;
          if (op_is_div) begin
            is_div_next = 1'b1;
            if (bus.src_b == '0) begin
              // Divide by zero skips iteration: HI takes the raw dividend, LO all ones
              state_next  = S_DONE;
              dz_next     = 1'b1;
              neg_lo_next = 1'b0;
              acc_next    = {bus.src_a, {DATA_W{1'b1}}};
            end else begin
              state_next  = S_DIV;
              neg_hi_next = sign_a;
              acc_next    = {{DATA_W{1'b0}}, abs_a};
              opnd_next   = abs_b;
            end
          end else begin
            is_div_next = 1'b0;
            opnd_next   = abs_a;
`ifdef HILO_FAST_MULT_EN
            state_next  = S_DONE;
            acc_next    = W2'(abs_a) * W2'(abs_b);
`else
            state_next  = S_MUL;
            acc_next    = {{DATA_W{1'b0}}, abs_b};
`endif
          end
        end else begin
          // MTHI/MTLO only land when no op competes for the unit
          if (bus.wr_hi_en) hi_next = bus.wr_data;
          if (bus.wr_lo_en) lo_next = bus.wr_data;
        end
      end
      S_MUL: begin
        acc_next = mul_acc;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) state_next = S_DONE;
      end
      S_DIV: begin
        acc_next = div_acc;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        hi_next    = hi_fin;
        lo_next    = lo_fin;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Exception flush abandons the op without touching HI/LO
    if (bus.cancel_in && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
    end
  end

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      is_div_reg <= is_div_next;
      neg_lo_reg <= neg_lo_next;
      neg_hi_reg <= neg_hi_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  always_comb begin
    bus.busy       = (state_reg != S_IDLE);
    bus.done_pulse = (state_reg == S_DONE) && !bus.cancel_in;
    bus.div_zero   = bus.done_pulse && dz_reg;
    bus.stall_out  = (bus.busy && (bus.op_valid || bus.hilo_rd || bus.wr_hi_en || bus.wr_lo_en))
                  || (!bus.busy && bus.op_valid && (bus.wr_hi_en || bus.wr_lo_en));
    bus.hi_out     = hi_reg;
    bus.lo_out     = lo_reg;
  end

endmodule

// File: tb/tb_hilo_muldiv_sched.sv
// Self-checking bench for hilo_muldiv_sched: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written stall/cancel/reset sequences.
module tb_hilo_muldiv_sched;

  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hilo_muldiv_sched_if #(.DATA_W(DATA_W)) bus ();

  hilo_muldiv_sched #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk_sig (clk),
    .rst_sig (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV truncating division for signed ops
  function automatic void model(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    longint sa, sb, q, r;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (code)
      2'd0: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (code == 2'd2) begin
          hi = a % b; lo = a / b;
        end else begin
          q = sa / sb; r = sa % sb;
          hi = 32'(r); lo = 32'(q);
        end
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] code, input logic [31:0] b);
    if (code[1] == 1'b0) begin
`ifdef HILO_FAST_MULT_EN
      return 0;
`else
      return DATA_W;
`endif
    end
    return (b == 32'h0) ? 0 : DATA_W;
  endfunction

  // Issue one op from IDLE, count cycles to done_pulse, then check HI/LO
  task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int   n;
    logic busy_ok;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = code; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.done_pulse && n < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_latency(code, b)));
    check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(edz));
    @(negedge clk);
    check({tag, " done_width"}, 64'(bus.done_pulse), 64'd0);
    check({tag, " busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi_out), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo_out), 64'(elo));
    $display("%s code=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", tag, code, a, b,
             bus.hi_out, bus.lo_out, n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rc;
    logic [31:0] ra, rb, ehi, elo, save_hi, save_lo;
    logic        edz, stall_ok, dp_seen;
    int          n;

    checks = 0;
    errors = 0;

    vecs[0] = '{2'd0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    vecs[2] = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFFF,  32'd16,         32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    vecs[4] = '{2'd2, 32'h0000_1234,  32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[6] = '{2'd3, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8] = '{2'd3, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{2'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};

    bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.hilo_rd = 1'b0; bus.wr_hi_en = 1'b0; bus.wr_lo_en = 1'b0; bus.wr_data = '0;
    bus.cancel_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset stall", 64'(bus.stall_out), 64'd0);
    check("reset done", 64'(bus.done_pulse), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    for (int i = 0; i < 40; i++) begin
      rc = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      model(rc, ra, rb, ehi, elo, edz);
      run_op($sformatf("rnd%0d", i), rc, ra, rb, ehi, elo, edz);
    end

    // MFHI issued mid-MULT stalls until the unit returns to IDLE
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'd1; bus.src_a = 32'hFFFF_FFFE; bus.src_b = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
`ifndef HILO_FAST_MULT_EN
    repeat (5) @(negedge clk);
    bus.hilo_rd = 1'b1;
    #1;
    stall_ok = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin
      if (!bus.stall_out) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("mfhi stall_while_busy", 64'(stall_ok), 64'd1);
`else
    bus.hilo_rd = 1'b1;
    wait_idle();
`endif
    check("mfhi stall_idle", 64'(bus.stall_out), 64'd0);
    check("mfhi hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("mfhi lo", 64'(bus.lo_out), 64'hFFFF_FFFA);
    $display("mfhi seq hi=%h lo=%h", bus.hi_out, bus.lo_out);
    bus.hilo_rd = 1'b0;

    // MTHI, then MTHI+MTLO together
    bus.wr_hi_en = 1'b1; bus.wr_data = 32'hAA;
    #1;
    check("mthi stall", 64'(bus.stall_out), 64'd0);
    @(negedge clk);
    bus.wr_hi_en = 1'b0;
    check("mthi hi", 64'(bus.hi_out), 64'hAA);
    check("mthi lo_kept", 64'(bus.lo_out), 64'hFFFF_FFFA);
    bus.wr_hi_en = 1'b1; bus.wr_lo_en = 1'b1; bus.wr_data = 32'h55;
    @(negedge clk);
    bus.wr_hi_en = 1'b0; bus.wr_lo_en = 1'b0;
    check("mthilo hi", 64'(bus.hi_out), 64'h55);
    check("mthilo lo", 64'(bus.lo_out), 64'h55);
    $display("mthi/mtlo seq hi=%h lo=%h", bus.hi_out, bus.lo_out);

    // op_valid wins over MTLO in IDLE
    bus.op_valid = 1'b1; bus.op_code = 2'd0; bus.src_a = 32'd3; bus.src_b = 32'd5;
    bus.wr_lo_en = 1'b1; bus.wr_data = 32'h77;
    #1;
    check("opwr stall", 64'(bus.stall_out), 64'd1);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.wr_lo_en = 1'b0;
    check("opwr lo_not_written", 64'(bus.lo_out), 64'h55);
    check("opwr accepted", 64'(bus.busy), 64'd1);
    wait_idle();
    check("opwr hi", 64'(bus.hi_out), 64'h0);
    check("opwr lo", 64'(bus.lo_out), 64'd15);
    $display("op+mtlo seq hi=%h lo=%h", bus.hi_out, bus.lo_out);

    // cancel mid-DIVU: HI/LO unchanged, no done_pulse
    save_hi = bus.hi_out; save_lo = bus.lo_out;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'd2; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel_in = 1'b1;
    #1;
    check("cancel done_suppressed", 64'(bus.done_pulse), 64'd0);
    @(negedge clk);
    bus.cancel_in = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    dp_seen = 1'b0;
    repeat (40) begin
      if (bus.done_pulse) dp_seen = 1'b1;
      @(negedge clk);
    end
    check("cancel no_done", 64'(dp_seen), 64'd0);
    check("cancel hi", 64'(bus.hi_out), 64'(save_hi));
    check("cancel lo", 64'(bus.lo_out), 64'(save_lo));
    $display("cancel seq hi=%h lo=%h", bus.hi_out, bus.lo_out);

    // New op presented while in DONE waits one cycle, then is accepted from IDLE
    bus.op_valid = 1'b1; bus.op_code = 2'd2; bus.src_a = 32'h1234; bus.src_b = 32'd0;
    @(negedge clk);
    bus.op_code = 2'd0; bus.src_a = 32'd6; bus.src_b = 32'd7;
    #1;
    check("done_op done_pulse", 64'(bus.done_pulse), 64'd1);
    check("done_op div_zero", 64'(bus.div_zero), 64'd1);
    check("done_op stall", 64'(bus.stall_out), 64'd1);
    @(negedge clk);
    check("done_op not_accepted", 64'(bus.busy), 64'd0);
    check("done_op dz_hi", 64'(bus.hi_out), 64'h1234);
    check("done_op dz_lo", 64'(bus.lo_out), 64'hFFFF_FFFF);
    check("done_op idle_stall", 64'(bus.stall_out), 64'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("done_op accepted", 64'(bus.busy), 64'd1);
    wait_idle();
    check("done_op hi", 64'(bus.hi_out), 64'h0);
    check("done_op lo", 64'(bus.lo_out), 64'd42);
    $display("op-in-done seq hi=%h lo=%h", bus.hi_out, bus.lo_out);

    // Asynchronous reset mid-DIV clears everything immediately
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'd3; bus.src_a = 32'hFFFF_FF00; bus.src_b = 32'd9;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid busy", 64'(bus.busy), 64'd0);
    check("rst_mid hi", 64'(bus.hi_out), 64'd0);
    check("rst_mid lo", 64'(bus.lo_out), 64'd0);
    check("rst_mid done", 64'(bus.done_pulse), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid stays_idle", 64'(bus.busy), 64'd0);
    check("rst_mid lo_kept", 64'(bus.lo_out), 64'd0);
    $display("reset-mid-div seq hi=%h lo=%h", bus.hi_out, bus.lo_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
